// File: rtl/lcd_bus_ctrl_if.sv
// Command-bus and panel-bus bundle for the 8080-style LCD bus master.
// The controller connects through the slave modport; the host/panel side uses master.
interface lcd_bus_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BUS_W  = 8
);
  logic [DATA_W-1:0] commData;
  logic [ADDR_W-1:0] commAddr;
  logic              wrEn;
  logic [BUS_W-1:0]  lcdDataIn;
  logic [BUS_W-1:0]  lcdData;
  logic              lcdDataOe;
  logic              lcdRs;
  logic              lcdWr;
  logic              lcdRd;
  logic              lcdCs;
  logic [BUS_W-1:0]  rdData;
  logic              rdValid;
  logic              busy;
  logic              fifoFull;
  logic              ovf;

  modport master (
    output commData, commAddr, wrEn, lcdDataIn,
    input  lcdData, lcdDataOe, lcdRs, lcdWr, lcdRd, lcdCs,
    input  rdData, rdValid, busy, fifoFull, ovf
  );

  modport slave (
    input  commData, commAddr, wrEn, lcdDataIn,
    output lcdData, lcdDataOe, lcdRs, lcdWr, lcdRd, lcdCs,
    output rdData, rdValid, busy, fifoFull, ovf
  );
endinterface

// File: rtl/lcd_bus_ctrl.sv
// 8080-style LCD bus master: decoded command-bus writes are queued and replayed
// onto the panel bus with programmable setup / strobe / hold timing.
module lcd_bus_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int BUS_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2,
  parameter int HOLD_CYC   = 1,
  parameter int DAT_ADDR   = 2,
  parameter int CMD_ADDR   = 3,
  parameter int RD_ADDR    = 5
) (
  input logic          clk,
  input logic          rst,
  lcd_bus_ctrl_if.slave bus
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_FIFO_ONE = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef struct packed {
    logic             isRead;
    logic             rs;
    logic [BUS_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // transaction queue
  entry_t           fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
  logic [PTR_W:0]   countReg;
  logic             ovfReg;
  logic             pushReq, pushOk, pop, isFull, isEmpty;
  entry_t           pushEntry, headEntry;

  // sequencer
  state_t           stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  entry_t           curReg, ent;

  // registered panel outputs
  logic             csReg, csNext, wrReg, wrNext, rdReg, rdNext, rsReg, rsNext;
  logic             oeReg, oeNext, rdValidReg, rdValidNext, rdCapture;
  logic [BUS_W-1:0] dataReg, dataNext, rdDataReg;

  assign isFull    = (countReg == (PTR_W+1)'(FIFO_DEPTH));
  assign isEmpty   = (countReg == '0);
  assign headEntry = fifoMem[rdPtrReg];
  // a full queue still accepts a push when the head leaves on the same edge
  assign pushOk    = pushReq && (!isFull || pop);

  always_comb begin
    pushReq   = 1'b0;
    pushEntry = '0;
    if (bus.wrEn) begin
      if (bus.commAddr == ADDR_W'(CMD_ADDR)) begin
        pushReq        = 1'b1;
        pushEntry.data = bus.commData[BUS_W-1:0];
      end else if (bus.commAddr == ADDR_W'(DAT_ADDR)) begin
        pushReq        = 1'b1;
        pushEntry.rs   = 1'b1;
        pushEntry.data = bus.commData[BUS_W-1:0];
      end else if (bus.commAddr == ADDR_W'(RD_ADDR)) begin
        pushReq          = 1'b1;
        pushEntry.isRead = 1'b1;
        pushEntry.rs     = bus.commData[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtrReg] <= pushEntry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      ovfReg   <= 1'b0;
    end else begin
      if (pushOk) wrPtrReg <= wrPtrReg + PTR_ONE;
      if (pop)    rdPtrReg <= rdPtrReg + PTR_ONE;
      if (pushOk && !pop)      countReg <= countReg + CNT_FIFO_ONE;
      else if (!pushOk && pop) countReg <= countReg - CNT_FIFO_ONE;
      if (pushReq && !pushOk) ovfReg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      curReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (pop) curReg <= headEntry;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    pop       = 1'b0;
    case (stateReg)
      IDLE: begin
        if (!isEmpty) begin
          pop       = 1'b1;
          stateNext = SETUP;
          cntNext   = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cntReg == '0) begin
          stateNext = STROBE;
          cntNext   = CNT_W'(PULSE_CYC - 1);
        end else begin
          cntNext = cntReg - CNT_ONE;
        end
      end
      STROBE: begin
        if (cntReg == '0) begin
          stateNext = HOLD;
          cntNext   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cntNext = cntReg - CNT_ONE;
        end
      end
      HOLD: begin
        if (cntReg == '0) stateNext = IDLE;
        else              cntNext   = cntReg - CNT_ONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // outputs are derived from the next state so they register together with it
  always_comb begin
    ent         = pop ? headEntry : curReg;
    csNext      = 1'b1;
    wrNext      = 1'b1;
    rdNext      = 1'b1;
    rsNext      = 1'b1;
    dataNext    = '0;
    oeNext      = 1'b0;
    rdCapture   = (stateReg == STROBE) && (stateNext == HOLD) && curReg.isRead;
    rdValidNext = rdCapture;
    if (stateNext != IDLE) begin
      csNext = 1'b0;
      rsNext = ent.rs;
      if (!ent.isRead) begin
        dataNext = ent.data;
        oeNext   = 1'b1;
      end
      if (stateNext == STROBE) begin
        if (ent.isRead) rdNext = 1'b0;
        else            wrNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csReg      <= 1'b1;
      wrReg      <= 1'b1;
      rdReg      <= 1'b1;
      rsReg      <= 1'b1;
      dataReg    <= '0;
      oeReg      <= 1'b0;
      rdDataReg  <= '0;
      rdValidReg <= 1'b0;
    end else begin
      csReg      <= csNext;
      wrReg      <= wrNext;
      rdReg      <= rdNext;
      rsReg      <= rsNext;
      dataReg    <= dataNext;
      oeReg      <= oeNext;
      rdValidReg <= rdValidNext;
      if (rdCapture) rdDataReg <= bus.lcdDataIn;
    end
  end

  assign bus.lcdCs     = csReg;
  assign bus.lcdWr     = wrReg;
  assign bus.lcdRd     = rdReg;
  assign bus.lcdRs     = rsReg;
  assign bus.lcdData   = dataReg;
  assign bus.lcdDataOe = oeReg;
  assign bus.rdData    = rdDataReg;
  assign bus.rdValid   = rdValidReg;
  assign bus.busy      = !isEmpty || (stateReg != IDLE);
  assign bus.fifoFull  = isFull;
  assign bus.ovf       = ovfReg;
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: two instances (default timing and SETUP=2/PULSE=4) share
// one stimulus stream and are checked every cycle against a transaction-offset model.
module tb_lcd_bus_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_bus_ctrl_if #(.DATA_W(8), .ADDR_W(3), .BUS_W(8)) ifA ();
  lcd_bus_ctrl_if #(.DATA_W(8), .ADDR_W(3), .BUS_W(8)) ifB ();

  assign ifB.commData  = ifA.commData;
  assign ifB.commAddr  = ifA.commAddr;
  assign ifB.wrEn      = ifA.wrEn;
  assign ifB.lcdDataIn = ifA.lcdDataIn;

  lcd_bus_ctrl dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  lcd_bus_ctrl #(.SETUP_CYC(2), .PULSE_CYC(4), .HOLD_CYC(1)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: each transaction is a CS-low window of S+P+H cycles, offset k
  typedef struct packed {logic isRead; logic rs; logic [7:0] data;} ent_t;
  ent_t       mBuf [2][4];
  int         mHead [2];
  int         mCnt [2];
  int         mK [2];
  bit         mActive [2];
  bit         mOvf [2];
  ent_t       mCur [2];
  logic [7:0] mRdData [2];

  function automatic int sOf(input int m); return (m == 0) ? 1 : 2; endfunction
  function automatic int pOf(input int m); return (m == 0) ? 2 : 4; endfunction
  function automatic int hOf(input int m); return 1; endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mHead[m] = 0; mCnt[m] = 0; mK[m] = 0; mActive[m] = 0;
      mOvf[m] = 0; mCur[m] = '0; mRdData[m] = 8'h00;
    end
  endtask

  task automatic modelStep(input int m);
    bit   pushReq = 0;
    bit   popped = 0;
    ent_t e = '0;
    int   tot = sOf(m) + pOf(m) + hOf(m);
    if (ifA.wrEn) begin
      case (ifA.commAddr)
        3'd3: begin pushReq = 1; e.data = ifA.commData; end
        3'd2: begin pushReq = 1; e.rs = 1; e.data = ifA.commData; end
        3'd5: begin pushReq = 1; e.isRead = 1; e.rs = ifA.commData[0]; end
        default: ;
      endcase
    end
    if (mActive[m]) begin
      mK[m]++;
      if (mK[m] == tot) mActive[m] = 0;
      else if (mCur[m].isRead && mK[m] == sOf(m) + pOf(m)) mRdData[m] = ifA.lcdDataIn;
    end else if (mCnt[m] != 0) begin
      mCur[m] = mBuf[m][mHead[m]];
      mHead[m] = (mHead[m] + 1) % 4;
      mCnt[m]--;
      popped = 1;
      mActive[m] = 1;
      mK[m] = 0;
    end
    if (pushReq) begin
      if (mCnt[m] == 4 && !popped) mOvf[m] = 1;
      else begin
        mBuf[m][(mHead[m] + mCnt[m]) % 4] = e;
        mCnt[m]++;
      end
    end
  endtask

  task automatic checkDut(input int m, input string p,
                          input logic cs, input logic wr, input logic rd, input logic rs,
                          input logic [7:0] dat, input logic oe, input logic [7:0] rdd,
                          input logic rv, input logic bsy, input logic full, input logic ov);
    bit   act = mActive[m];
    int   k = mK[m];
    ent_t c = mCur[m];
    bit   strobe = act && k >= sOf(m) && k < sOf(m) + pOf(m);
    check({p, ".lcdCs"},     32'(cs),  32'(!act));
    check({p, ".lcdWr"},     32'(wr),  32'(!(strobe && !c.isRead)));
    check({p, ".lcdRd"},     32'(rd),  32'(!(strobe && c.isRead)));
    check({p, ".lcdRs"},     32'(rs),  32'(act ? c.rs : 1'b1));
    check({p, ".lcdData"},   32'(dat), 32'((act && !c.isRead) ? c.data : 8'h00));
    check({p, ".lcdDataOe"}, 32'(oe),  32'(act && !c.isRead));
    check({p, ".rdData"},    32'(rdd), 32'(mRdData[m]));
    check({p, ".rdValid"},   32'(rv),  32'(act && c.isRead && k == sOf(m) + pOf(m)));
    check({p, ".busy"},      32'(bsy), 32'(act || mCnt[m] != 0));
    check({p, ".fifoFull"},  32'(full), 32'(mCnt[m] == 4));
    check({p, ".ovf"},       32'(ov),  32'(mOvf[m]));
  endtask

  task automatic checkAll();
    checkDut(0, "A", ifA.lcdCs, ifA.lcdWr, ifA.lcdRd, ifA.lcdRs, ifA.lcdData, ifA.lcdDataOe,
             ifA.rdData, ifA.rdValid, ifA.busy, ifA.fifoFull, ifA.ovf);
    checkDut(1, "B", ifB.lcdCs, ifB.lcdWr, ifB.lcdRd, ifB.lcdRs, ifB.lcdData, ifB.lcdDataOe,
             ifB.rdData, ifB.rdValid, ifB.busy, ifB.fifoFull, ifB.ovf);
  endtask

  // waveform measurements independent of the model
  int         cyc = 0;
  int         csLowA, wrLowA, rdLowA, rvCntA, wrLowB, csFallB, wrFallB;
  bit         prevWrA = 1, prevCsB = 1, prevWrB = 1;
  logic [7:0] strobeLog [$];
  bit         useFix = 0;
  logic [7:0] dinFix = 8'h00;

  task automatic clearMeas();
    csLowA = 0; wrLowA = 0; rdLowA = 0; rvCntA = 0; wrLowB = 0; csFallB = -1; wrFallB = -1;
    strobeLog.delete();
  endtask

  task automatic tick(input bit we, input logic [2:0] a, input logic [7:0] d);
    ifA.wrEn      = we;
    ifA.commAddr  = a;
    ifA.commData  = d;
    ifA.lcdDataIn = useFix ? dinFix : 8'($urandom);
    @(posedge clk);
    if (rst) modelReset();
    else begin modelStep(0); modelStep(1); end
    #1;
    cyc++;
    checkAll();
    if (!ifA.lcdCs) csLowA++;
    if (!ifA.lcdWr) wrLowA++;
    if (!ifA.lcdRd) rdLowA++;
    if (ifA.rdValid) rvCntA++;
    if (!ifB.lcdWr) wrLowB++;
    if (prevWrA && !ifA.lcdWr) strobeLog.push_back(ifA.lcdData);
    if (prevCsB && !ifB.lcdCs) csFallB = cyc;
    if (prevWrB && !ifB.lcdWr) wrFallB = cyc;
    prevWrA = ifA.lcdWr;
    prevCsB = ifB.lcdCs;
    prevWrB = ifB.lcdWr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 8'h00);
  endtask

  logic [2:0] addrTab [8] = '{3'd2, 3'd3, 3'd5, 3'd2, 3'd3, 3'd5, 3'd0, 3'd7};

  initial begin
    rst = 1'b1;
    ifA.wrEn = 1'b0; ifA.commAddr = '0; ifA.commData = '0; ifA.lcdDataIn = '0;
    modelReset();
    clearMeas();
    idle(2);
    rst = 1'b0;
    idle(2);

    // command write
    clearMeas();
    tick(1'b1, 3'd3, 8'h2C);
    idle(8);
    $display("cmd write: csLow=%0d wrLow=%0d", csLowA, wrLowA);
    check("cmd.csLow", 32'(csLowA), 32'd4);
    check("cmd.wrLow", 32'(wrLowA), 32'd2);
    check("cmd.rdLow", 32'(rdLowA), 32'd0);
    check("cmd.nStrobe", 32'(strobeLog.size()), 32'd1);
    if (strobeLog.size() > 0) check("cmd.data", 32'(strobeLog[0]), 32'h2C);

    // data write
    clearMeas();
    tick(1'b1, 3'd2, 8'hA5);
    idle(8);
    $display("data write: csLow=%0d wrLow=%0d", csLowA, wrLowA);
    check("dat.csLow", 32'(csLowA), 32'd4);
    check("dat.wrLow", 32'(wrLowA), 32'd2);
    if (strobeLog.size() > 0) check("dat.data", 32'(strobeLog[0]), 32'hA5);

    // burst with overflow
    clearMeas();
    for (int i = 1; i <= 6; i++) begin
      tick(1'b1, 3'd2, 8'(i));
      if (i == 5) check("burst.fullAfter5", 32'(ifA.fifoFull), 32'd1);
    end
    check("burst.ovf", 32'(ifA.ovf), 32'd1);
    idle(30);
    $display("burst: strobes=%0d ovf=%0b", strobeLog.size(), ifA.ovf);
    check("burst.nStrobe", 32'(strobeLog.size()), 32'd5);
    for (int i = 0; i < strobeLog.size() && i < 5; i++)
      check("burst.data", 32'(strobeLog[i]), 32'(i + 1));

    // panel read
    clearMeas();
    useFix = 1; dinFix = 8'h5A;
    tick(1'b1, 3'd5, 8'h01);
    idle(12);
    useFix = 0;
    $display("read: rdData=%0h rdLow=%0d rdValid pulses=%0d", ifA.rdData, rdLowA, rvCntA);
    check("rd.rdDataA", 32'(ifA.rdData), 32'h5A);
    check("rd.rdDataB", 32'(ifB.rdData), 32'h5A);
    check("rd.rdLow", 32'(rdLowA), 32'd2);
    check("rd.wrLow", 32'(wrLowA), 32'd0);
    check("rd.validPulses", 32'(rvCntA), 32'd1);

    // reset during a strobe of a queued burst
    for (int i = 0; i < 3; i++) tick(1'b1, 3'd2, 8'(8'h40 + i));
    for (int w = 0; w < 20 && ifA.lcdWr; w++) idle(1);
    check("rst.reachedStrobe", 32'(ifA.lcdWr), 32'd0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    $display("async reset: lcdCs=%0b lcdWr=%0b busy=%0b", ifA.lcdCs, ifA.lcdWr, ifA.busy);
    checkAll();
    idle(2);
    rst = 1'b0;
    clearMeas();
    idle(20);
    check("rst.noCs", 32'(csLowA), 32'd0);
    check("rst.noWr", 32'(wrLowA), 32'd0);
    check("rst.busy", 32'(ifA.busy), 32'd0);

    // ignored addresses
    clearMeas();
    tick(1'b1, 3'd0, 8'h11);
    check("ign.busy0", 32'(ifA.busy), 32'd0);
    tick(1'b1, 3'd7, 8'h22);
    check("ign.busy7", 32'(ifA.busy), 32'd0);
    idle(8);
    check("ign.noCs", 32'(csLowA), 32'd0);

    // longer timing on instance B
    clearMeas();
    tick(1'b1, 3'd2, 8'h77);
    idle(14);
    $display("timing B: wr falls %0d after cs, wrLow=%0d", wrFallB - csFallB, wrLowB);
    check("tmB.csFallSeen", 32'(csFallB >= 0), 32'd1);
    check("tmB.setupGap", 32'(wrFallB - csFallB), 32'd2);
    check("tmB.wrLow", 32'(wrLowB), 32'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      tick(($urandom % 3) != 0, addrTab[$urandom % 8], 8'($urandom));
    idle(60);
    check("rand.drainA", 32'(ifA.busy), 32'd0);
    check("rand.drainB", 32'(ifB.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_bus_ctrl.md
# lcd_bus_ctrl

Parametrised 8080-style parallel LCD bus master on the command bus: command-bus writes to dedicated addresses are queued in a FIFO and replayed onto the panel bus with programmable setup, strobe and hold timing. It supports command writes, data writes and panel reads, and reports busy, full and overflow status. All bus timing is synchronous to `clk`; `wrEn` is a single-cycle synchronous strobe.

## Interface
- `DATA_W`, 8: command-bus data width; must be ≥ `BUS_W`.
- `ADDR_W`, 3: command-bus address width.
- `BUS_W`, 8: panel data bus width.
- `FIFO_DEPTH`, 4: transaction queue depth; must be a power of two and ≥ 2.
- `SETUP_CYC`, 1: cycles with CS low before the strobe; ≥ 1.
- `PULSE_CYC`, 2: cycles with WR/RD low; ≥ 1.
- `HOLD_CYC`, 1: cycles with CS low after the strobe; ≥ 1.
- `DAT_ADDR`, 2 / `CMD_ADDR`, 3 / `RD_ADDR`, 5: decoded addresses.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `commData` in DATA_W: write data.
- `commAddr` in ADDR_W: write address.
- `wrEn` in 1: single-cycle write strobe.
- `lcdDataIn` in BUS_W: panel read data.
- `lcdData` out BUS_W: panel write data.
- `lcdDataOe` out 1: output enable for `lcdData`.
- `lcdRs`, `lcdWr`, `lcdRd`, `lcdCs` out 1: panel controls.
- `rdData` out BUS_W: last read value.
- `rdValid` out 1: one-cycle pulse when a read completes.
- `busy` out 1: FIFO is non-empty or the FSM is not in IDLE.
- `fifoFull` out 1: FIFO holds `FIFO_DEPTH` entries.
- `ovf` out 1: sticky flag, set when a push is dropped.

## Operation
- **Push decode.** A push occurs when `wrEn` is high at a rising edge and `commAddr` is one of the decoded addresses. Each entry is {isRead, rs, data[BUS_W-1:0]}, with data taken from `commData` LSBs.
  - `CMD_ADDR`: write, rs=0.
  - `DAT_ADDR`: write, rs=1.
  - `RD_ADDR`: read, rs=`commData[0]`, data ignored.
  - Any other address: no effect.
- **Full FIFO.** When full and no pop happens on the same edge, the push is dropped and `ovf` is set to 1. `ovf` clears only on reset.
- **Simultaneous push and pop.** Both take effect, including when the FIFO is full; the count stays unchanged.
- **FSM states:** IDLE, SETUP, STROBE, HOLD. A single down-counter, reloaded on each state entry, times SETUP, STROBE and HOLD.
  - IDLE: if the FIFO is non-empty, pop the head, latch it into the output registers and go to SETUP.
  - SETUP: stay `SETUP_CYC` cycles, then go to STROBE.
  - STROBE: stay `PULSE_CYC` cycles, then go to HOLD. For a read, `lcdDataIn` is sampled at the edge that leaves STROBE.
  - HOLD: stay `HOLD_CYC` cycles, then go to IDLE.
- **Outputs.** All panel outputs are registered.
  - `lcdCs` = 0 in SETUP, STROBE and HOLD; otherwise 1.
  - `lcdWr` = 0 in STROBE for a write; otherwise 1.
  - `lcdRd` = 0 in STROBE for a read; otherwise 1.
  - `lcdRs` = the latched rs while CS is low; 1 in IDLE.
  - `lcdData` = the latched data and `lcdDataOe` = 1 during a write transaction (SETUP through HOLD); otherwise `lcdData` = 0 and `lcdDataOe` = 0.
- **Read completion.** `rdData` is updated at the STROBE→HOLD edge and holds until the next read. `rdValid` is high for exactly the first HOLD cycle.
- **Reset values:** `lcdCs`, `lcdWr`, `lcdRd`, `lcdRs` = 1; `lcdData`, `lcdDataOe`, `rdData`, `rdValid`, `busy`, `fifoFull`, `ovf` = 0. The FIFO is empty and the FSM is in IDLE.
- **Reset mid-transaction:** outputs return to their reset values immediately (asynchronously). Queued entries are discarded, and no partial strobe is resumed after `rst` falls.

## Timing
- Push at edge N: entry visible from N. FSM pops at N+1; `lcdCs`, `lcdRs` and `lcdData` are valid from N+1.
- Strobe: `lcdWr` or `lcdRd` low from N+1+`SETUP_CYC` for `PULSE_CYC` cycles.
- CS low duration: `SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC` cycles. CS is high for at least 1 IDLE cycle between transactions.
- Throughput: `SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+1 cycles per transaction (5 at defaults).
- `busy` rises at N (registered with the push) and falls at the edge that enters IDLE with the FIFO empty.
- `fifoFull` and `ovf` update on the same edge as the push or pop that changes them.

## Test plan
- **Command write.** After reset, write addr 3 with 0x2C at edge N. Required:
  - `lcdCs` low N+1..N+5 (4 cycles), `lcdRs`=0, `lcdData`=0x2C, `lcdDataOe`=1.
  - `lcdWr` low N+2..N+4 (2 cycles); `lcdRd` stays 1.
  - `busy` falls at N+5.
- **Data write.** Write addr 2 with 0xA5. Required: identical timing to the command write, `lcdRs`=1.
- **Burst and overflow.** Write 6 consecutive cycles to addr 2 with 0x01..0x06. Required:
  - Bus shows 0x01..0x05, 5 cycles apart, with 1 CS-high cycle between transactions.
  - 0x06 is dropped; `ovf`=1; `fifoFull` is high after the 5th push.
- **Read.** Write addr 5 with 0x01, `lcdDataIn`=0x5A. Required:
  - `lcdRd` low 2 cycles, `lcdWr`=1, `lcdDataOe`=0, `lcdRs`=1.
  - `rdData`=0x5A and a 1-cycle `rdValid` in the first HOLD cycle.
- **Reset mid-operation.** Assert `rst` during STROBE of a queued burst. Required: all outputs take reset values immediately; no bus activity after release; `busy`=0.
- **Ignored addresses and timing override.** Write addr 0 and addr 7 → no bus activity, `busy` stays 0. Rebuild with `PULSE_CYC`=4, `SETUP_CYC`=2 and write addr 2 → `lcdWr` low 4 cycles starting 2 cycles after CS falls.
